// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register access arbiter: response status and arbiter FSM states.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } rggen_status_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } rggen_arbiter_state_t;

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request at or after pointer_i, wrapping modulo HOSTS.
module rggen_round_robin_arbiter #(
   parameter int HOSTS       = 2,
   parameter int INDEX_WIDTH = $clog2(HOSTS)
) (
   input  logic [HOSTS-1:0]       request_i,
   input  logic [INDEX_WIDTH-1:0] pointer_i,
   output logic [HOSTS-1:0]       grant_o,
   output logic [INDEX_WIDTH-1:0] index_o
);

   always_comb begin
      int   slot;
      logic found;
      grant_o = '0;
      index_o = '0;
      found   = 1'b0;
      slot    = 0;
      for (int i = 0; i < HOSTS; i++) begin
         slot = (int'(pointer_i) + i) % HOSTS;
         if (!found && request_i[slot]) begin
            found         = 1'b1;
            grant_o[slot] = 1'b1;
            index_o       = INDEX_WIDTH'(slot);
         end
      end
   end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Shares one rggen register-block port between HOSTS masters, round-robin, one access at a time.
// Define RGGEN_REGISTER_ACCESS_TIMEOUT_EN to abort accesses that stall for TIMEOUT_CYCLES.
//
// state    | meaning
// IDLE     | sample host requests, launch the winner's access
// ACCESS   | payload held on reg_*, waiting for reg_done (or timeout)
// COMPLETE | one-cycle host_done pulse with captured read data / status
module rggen_register_access_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter int HOSTS          = 2,
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [HOSTS-1:0]               host_request_i,
   input  logic [HOSTS*ADDRESS_WIDTH-1:0] host_address_i,
   input  logic [HOSTS-1:0]               host_write_i,
   input  logic [HOSTS*DATA_WIDTH-1:0]    host_write_data_i,
   input  logic [HOSTS*DATA_WIDTH/8-1:0]  host_strobe_i,
   output logic [HOSTS-1:0]               host_done_o,
   output logic [DATA_WIDTH-1:0]          host_read_data_o,
   output logic [1:0]                     host_status_o,
   output logic                           reg_request_o,
   output logic [ADDRESS_WIDTH-1:0]       reg_address_o,
   output logic                           reg_write_o,
   output logic [DATA_WIDTH-1:0]          reg_write_data_o,
   output logic [DATA_WIDTH/8-1:0]        reg_strobe_o,
   input  logic                           reg_done_i,
   input  logic [DATA_WIDTH-1:0]          reg_read_data_i,
   input  logic [1:0]                     reg_status_i
);

   localparam int IW = $clog2(HOSTS);
   localparam int SW = DATA_WIDTH / 8;

   if (HOSTS < 2 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("rggen_register_access_arbiter: invalid parameter set");
   end

   rggen_arbiter_state_t     state_q, state_d;
   logic [IW-1:0]            ptr_q, ptr_d;
   logic [HOSTS-1:0]         grant_q, grant_d;
   logic                     reg_request_q, reg_request_d;
   logic [ADDRESS_WIDTH-1:0] reg_address_q, reg_address_d;
   logic                     reg_write_q, reg_write_d;
   logic [DATA_WIDTH-1:0]    reg_write_data_q, reg_write_data_d;
   logic [SW-1:0]            reg_strobe_q, reg_strobe_d;
   logic [HOSTS-1:0]         host_done_q, host_done_d;
   logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
   rggen_status_t            status_q, status_d;
   logic [HOSTS-1:0]         arb_grant;
   logic [IW-1:0]            arb_index;

`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
`endif

   rggen_round_robin_arbiter #(
      .HOSTS       (HOSTS),
      .INDEX_WIDTH (IW)
   ) u_arbiter (
      .request_i (host_request_i),
      .pointer_i (ptr_q),
      .grant_o   (arb_grant),
      .index_o   (arb_index)
   );

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      grant_d          = grant_q;
      reg_request_d    = reg_request_q;
      reg_address_d    = reg_address_q;
      reg_write_d      = reg_write_q;
      reg_write_data_d = reg_write_data_q;
      reg_strobe_d     = reg_strobe_q;
      host_done_d      = '0;
      read_data_d      = read_data_q;
      status_d         = status_q;
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
      timer_d          = timer_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|host_request_i) begin
               state_d          = ACCESS;
               grant_d          = arb_grant;
               ptr_d            = (int'(arb_index) == HOSTS - 1) ? '0 : arb_index + 1'b1;
               reg_request_d    = 1'b1;
               reg_address_d    = host_address_i[arb_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
               reg_write_d      = host_write_i[arb_index];
               reg_write_data_d = host_write_data_i[arb_index*DATA_WIDTH +: DATA_WIDTH];
               reg_strobe_d     = host_strobe_i[arb_index*SW +: SW];
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
               timer_d          = '0;
`endif
            end
         end
         ACCESS: begin
            if (reg_done_i) begin
               state_d       = COMPLETE;
               reg_request_d = 1'b0;
               read_data_d   = reg_read_data_i;
               status_d      = rggen_status_t'(reg_status_i);
               host_done_d   = grant_q;
            end
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
            else begin
               timer_d = timer_q + 1'b1;
               // A stalled block gets SLVERR with zero data; a same-cycle reg_done takes the branch above.
               if (timer_d == TW'(TIMEOUT_CYCLES)) begin
                  state_d       = COMPLETE;
                  reg_request_d = 1'b0;
                  read_data_d   = '0;
                  status_d      = SLVERR;
                  host_done_d   = grant_q;
               end
            end
`endif
         end
         COMPLETE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q          <= IDLE;
         ptr_q            <= '0;
         grant_q          <= '0;
         reg_request_q    <= 1'b0;
         reg_address_q    <= '0;
         reg_write_q      <= 1'b0;
         reg_write_data_q <= '0;
         reg_strobe_q     <= '0;
         host_done_q      <= '0;
         read_data_q      <= '0;
         status_q         <= OKAY;
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
         timer_q          <= '0;
`endif
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         grant_q          <= grant_d;
         reg_request_q    <= reg_request_d;
         reg_address_q    <= reg_address_d;
         reg_write_q      <= reg_write_d;
         reg_write_data_q <= reg_write_data_d;
         reg_strobe_q     <= reg_strobe_d;
         host_done_q      <= host_done_d;
         read_data_q      <= read_data_d;
         status_q         <= status_d;
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
         timer_q          <= timer_d;
`endif
      end
   end

   assign host_done_o      = host_done_q;
   assign host_read_data_o = read_data_q;
   assign host_status_o    = status_q;
   assign reg_request_o    = reg_request_q;
   assign reg_address_o    = reg_address_q;
   assign reg_write_o      = reg_write_q;
   assign reg_write_data_o = reg_write_data_q;
   assign reg_strobe_o     = reg_strobe_q;

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Bench for rggen_register_access_arbiter: random hosts and register-block responder checked
// every cycle against a transaction-level round-robin model.
module tb_rggen_register_access_arbiter;

   localparam int H  = 3;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic [H-1:0]      host_request = '0;
   logic [H*AW-1:0]   host_address = '0;
   logic [H-1:0]      host_write = '0;
   logic [H*DW-1:0]   host_write_data = '0;
   logic [H*SW-1:0]   host_strobe = '0;
   logic [H-1:0]      host_done;
   logic [DW-1:0]     host_read_data;
   logic [1:0]        host_status;
   logic              reg_request;
   logic [AW-1:0]     reg_address;
   logic              reg_write;
   logic [DW-1:0]     reg_write_data;
   logic [SW-1:0]     reg_strobe;
   logic              reg_done = 1'b0;
   logic [DW-1:0]     reg_read_data = '0;
   logic [1:0]        reg_status = '0;

   rggen_register_access_arbiter #(
      .HOSTS          (H),
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .host_request_i    (host_request),
      .host_address_i    (host_address),
      .host_write_i      (host_write),
      .host_write_data_i (host_write_data),
      .host_strobe_i     (host_strobe),
      .host_done_o       (host_done),
      .host_read_data_o  (host_read_data),
      .host_status_o     (host_status),
      .reg_request_o     (reg_request),
      .reg_address_o     (reg_address),
      .reg_write_o       (reg_write),
      .reg_write_data_o  (reg_write_data),
      .reg_strobe_o      (reg_strobe),
      .reg_done_i        (reg_done),
      .reg_read_data_i   (reg_read_data),
      .reg_status_i      (reg_status)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model
   int          m_ptr, m_owner, m_age, m_cool;
   bit          m_busy;
   logic          exp_req;
   logic [AW-1:0] exp_addr;
   logic          exp_wr;
   logic [DW-1:0] exp_wdata;
   logic [SW-1:0] exp_strb;
   logic [H-1:0]  exp_done;
   logic [DW-1:0] exp_rdata;
   logic [1:0]    exp_status;

   // stimulus knobs
   logic [H-1:0] host_en = '0;
   int unsigned  p_req = 0, p_rereq = 0, p_drop = 0, p_spur = 0;
   int           rsp_delay = 0, rsp_cur = 0, rsp_wait = 0;
   bit           rsp_fixed = 1'b0;
   logic [DW-1:0] rsp_value = '0;
   logic [H-1:0] obs_done = '0;
   logic         obs_req = 1'b0, prev_req = 1'b0;
   bit           check_spacing = 1'b0;
   int           last_rise = -1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic compare_outputs();
      check_val("reg_request",    64'(reg_request),    64'(exp_req));
      check_val("reg_address",    64'(reg_address),    64'(exp_addr));
      check_val("reg_write",      64'(reg_write),      64'(exp_wr));
      check_val("reg_write_data", 64'(reg_write_data), 64'(exp_wdata));
      check_val("reg_strobe",     64'(reg_strobe),     64'(exp_strb));
      check_val("host_done",      64'(host_done),      64'(exp_done));
      check_val("host_read_data", 64'(host_read_data), 64'(exp_rdata));
      check_val("host_status",    64'(host_status),    64'(exp_status));
      if (check_spacing && reg_request && !prev_req) begin
         if (last_rise >= 0) check_val("rise_spacing", 64'(cyc - last_rise), 64'd3);
         last_rise = cyc;
      end
      prev_req = reg_request;
      obs_done = host_done;
      obs_req  = reg_request;
      cyc++;
   endtask

   task automatic host_set(input int h, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
      host_address[h*AW +: AW]    = a;
      host_write[h]               = w;
      host_write_data[h*DW +: DW] = d;
      host_strobe[h*SW +: SW]     = s;
      host_request[h]             = 1'b1;
   endtask

   task automatic host_new(input int h);
      host_set(h, AW'($urandom), 1'($urandom), $urandom, SW'($urandom));
   endtask

   task automatic model_finish(input logic [DW-1:0] d, input logic [1:0] s);
      exp_req           = 1'b0;
      exp_done[m_owner] = 1'b1;
      exp_rdata         = d;
      exp_status        = s;
      m_busy            = 1'b0;
      m_cool            = 1;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_age = 0; m_cool = 0; m_busy = 1'b0;
      exp_req = 1'b0; exp_addr = '0; exp_wr = 1'b0; exp_wdata = '0; exp_strb = '0;
      exp_done = '0; exp_rdata = '0; exp_status = 2'd0;
   endtask

   // Drives inputs for the next rising edge and predicts the outputs after it.
   task automatic drive_and_model();
      bit found;
      for (int h = 0; h < H; h++) begin
         if (obs_done[h]) begin
            if ($urandom_range(99) < p_rereq) host_new(h);
            else host_request[h] = 1'b0;
         end else if (!host_request[h]) begin
            if (host_en[h] && $urandom_range(99) < p_req) host_new(h);
         end else if ($urandom_range(99) < p_drop) begin
            host_request[h] = 1'b0;
         end
      end
      reg_done = 1'b0;
      if (obs_req) begin
         if (rsp_wait == rsp_cur) reg_done = 1'b1;
         rsp_wait++;
      end else begin
         rsp_wait = 0;
         rsp_cur  = (rsp_delay < 0) ? int'($urandom_range(10)) : rsp_delay;
         if ($urandom_range(99) < p_spur) reg_done = 1'b1;
      end
      reg_read_data = rsp_fixed ? rsp_value : $urandom;
      reg_status    = rsp_fixed ? 2'd0 : 2'($urandom_range(3));

      exp_done = '0;
      if (m_busy) begin
         m_age++;
         if (reg_done) model_finish(reg_read_data, reg_status);
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
         else if (m_age == TO) model_finish('0, 2'd2);
`endif
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (|host_request) begin
         found = 1'b0;
         for (int k = 0; k < H; k++) begin
            int h;
            h = (m_ptr + k) % H;
            if (!found && host_request[h]) begin
               found     = 1'b1;
               m_owner   = h;
               m_ptr     = (h + 1) % H;
               m_busy    = 1'b1;
               m_age     = 0;
               exp_req   = 1'b1;
               exp_addr  = host_address[h*AW +: AW];
               exp_wr    = host_write[h];
               exp_wdata = host_write_data[h*DW +: DW];
               exp_strb  = host_strobe[h*SW +: SW];
            end
         end
      end
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_and_model();
         @(negedge clk_i);
         compare_outputs();
      end
   endtask

   task automatic do_reset();
      rst_n_i      = 1'b0;
      host_request = '0;
      reg_done     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      compare_outputs();
      rst_n_i = 1'b1;
   endtask

   task automatic knobs(input logic [H-1:0] en, input int unsigned rq, input int unsigned rr,
                        input int unsigned dr, input int unsigned sp, input int dly);
      host_en = en; p_req = rq; p_rereq = rr; p_drop = dr; p_spur = sp; rsp_delay = dly;
   endtask

   initial begin
      model_reset();
      do_reset();

      // single read from host 0, 1-cycle reg_done
      knobs('0, 0, 0, 0, 0, 0);
      rsp_fixed = 1'b1; rsp_value = 32'hCAFE_0001;
      host_set(0, 16'h0010, 1'b0, 32'h0, 4'hF);
      cycle(6);
      rsp_fixed = 1'b0;

      // hosts 0 and 1 together, both re-requesting: order 0,1,0,1
      knobs('0, 0, 100, 0, 0, 0);
      host_new(0); host_new(1);
      cycle(12);
      knobs('0, 0, 0, 0, 0, 0);
      cycle(6);

      // host 1 write, payload held through a 5-cycle reg_done delay
      knobs('0, 0, 0, 0, 0, 5);
      host_set(1, 16'h1234, 1'b1, 32'hA5A5_A5A5, 4'b0011);
      cycle(12);

      // back-to-back reads from one host: requests 3 cycles apart
      knobs('0, 0, 100, 0, 0, 0);
      check_spacing = 1'b1; last_rise = -1;
      host_set(2, 16'h0040, 1'b0, 32'h0, 4'hF);
      cycle(15);
      check_spacing = 1'b0;
      knobs('0, 0, 0, 0, 0, 0);
      cycle(4);

`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
      // block never answers; stray reg_done after the abort must be ignored
      knobs('0, 0, 0, 0, 100, 1000000);
      host_new(0);
      cycle(TO + 8);
      knobs('0, 0, 0, 0, 0, 0);
      cycle(4);
`endif

      // reset during ACCESS after host 0 was granted, then host 0 must win again
      knobs('0, 0, 0, 0, 0, 1000000);
      host_new(0); host_new(1);
      cycle(3);
      #2 rst_n_i = 1'b0;
      #1;
      check_val("async_reset_req",   64'(reg_request), 64'd0);
      check_val("async_reset_done",  64'(host_done),   64'd0);
      check_val("async_reset_addr",  64'(reg_address), 64'd0);
      check_val("async_reset_wdata", 64'(reg_write_data), 64'd0);
      do_reset();
      knobs('0, 0, 0, 0, 0, 0);
      host_new(0); host_new(1);
      cycle(10);

      // randomized traffic with protocol noise
      knobs('1, 40, 50, 2, 20, -1);
      cycle(1500);
      do_reset();
      cycle(1500);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rggen_register_access_arbiter.md
Name: rggen_register_access_arbiter

Overview:
- Shares one register-block access port between HOSTS independent bus masters, e.g. a CPU bridge and a debug/JTAG bridge.
- Drives the request side of the register block's register_if fan-out and returns read data and status to the granted host.
- Round-robin arbitration with registered outputs.
- Holds each grant until the register block completes the access, so accesses are never interleaved.

Parameters:
- HOSTS, 2, number of requesting hosts (>=2).
- ADDRESS_WIDTH, 16, register address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, cycles before a pending access is aborted (only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- host_request  input  HOSTS  per-host access request; held until host_done.
- host_address  input  HOSTS*ADDRESS_WIDTH  per-host address, host i at slice i.
- host_write  input  HOSTS  1=write, 0=read.
- host_write_data  input  HOSTS*DATA_WIDTH  per-host write data.
- host_strobe  input  HOSTS*DATA_WIDTH/8  per-host byte strobes.
- host_done  output  HOSTS  one-cycle completion pulse to the granted host.
- host_read_data  output  DATA_WIDTH  read data; valid with host_done.
- host_status  output  2  rggen_status_t; valid with host_done.
- reg_request  output  1  access request to the register block.
- reg_address  output  ADDRESS_WIDTH  address.
- reg_write  output  1  direction.
- reg_write_data  output  DATA_WIDTH  write data.
- reg_strobe  output  DATA_WIDTH/8  byte strobes.
- reg_done  input  1  register block completion.
- reg_read_data  input  DATA_WIDTH  read data from register block.
- reg_status  input  2  status from register block.

Behaviour:
- Reset: every output 0; FSM in IDLE; round-robin pointer = 0, so host 0 has highest priority.
- FSM has three states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - Host requests are sampled combinationally.
  - If any are asserted, grant the first asserted host at or after the pointer, wrapping modulo HOSTS.
  - Register that host's address, write, write_data and strobe onto reg_*.
  - Set reg_request=1 and go to ACCESS. The request appears 1 cycle after it is sampled.
  - Pointer becomes grant+1 (mod HOSTS).
- ACCESS:
  - reg_request and all reg_* payload stay stable until reg_done=1.
  - On reg_done: clear reg_request, capture reg_read_data and reg_status, go to COMPLETE.
- COMPLETE:
  - host_done[grant]=1 for exactly one cycle; host_read_data and host_status hold the captured values.
  - Next state is IDLE.
  - Minimum turnaround per access is 3 cycles, including a 1-cycle reg_done.
- Outside COMPLETE: host_done=0 and host_read_data/host_status hold their last value.
- Host protocol: a host deasserts or updates host_request on the edge after it sees host_done. IDLE then samples the new value, so back-to-back accesses from the same host cost no extra cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. A host asserting continuously is granted at least once every HOSTS accesses.
- A host dropping host_request during ACCESS is a protocol violation. The access still completes and host_done still pulses.
- reg_done in IDLE or COMPLETE is ignored.
- Reset asserted mid-access: immediate return to reset state. No host_done is issued and the register block sees reg_request fall.

Optional Feature:
- Macro: RGGEN_REGISTER_ACCESS_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each cycle in ACCESS without reg_done.
  - When the counter reaches TIMEOUT_CYCLES, reg_request clears and the FSM goes to COMPLETE with host_status=SLVERR and host_read_data=0.
  - reg_done in the same cycle as the timeout wins, and the normal response is returned.
- When undefined: no counter; ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package rggen_rtl_pkg holds rggen_status_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the arbiter state enum.
- One natural sub-module: rggen_round_robin_arbiter, a combinational grant from request vector plus pointer, returning a one-hot grant and its index.

Test Plan:
- Host 0 reads 0x0010; reg_done held 1 cycle with data 0xCAFE_0001 and status OKAY -> reg_request high 1 cycle after request; host_done[0] 1 cycle after reg_done; read data 0xCAFE_0001, status 0.
- Hosts 0 and 1 request together at reset, and both re-request immediately -> grant order 0,1,0,1; neither waits more than one access.
- Host 1 writes 0xA5A5_A5A5 with strobe 4'b0011 -> reg_write=1, reg_write_data and reg_strobe exact; payload stable through a 5-cycle reg_done delay.
- Single host issues back-to-back reads -> reg_request rising edges exactly 3 cycles apart with 1-cycle reg_done.
- With timeout enabled and TIMEOUT_CYCLES=8, reg_done never asserted -> reg_request drops after 8 ACCESS cycles; host_status=2, data 0; a later reg_done is ignored.
- rst_n pulled low in ACCESS -> all outputs 0 asynchronously; no host_done; after release, host 0 is granted first.
